// File: rtl/age_issue_queue.sv
// age_issue_queue: age-ordered issue queue.
// Each entry holds a payload, which carries its robid, and a set of readiness
// condition bits. The oldest entry whose condition bits are all set is
// offered on the dequeue port, and no older non-ready entry can hold it back.
// Entry age is tracked with an age matrix: older_q[i][j] = 1 means entry j is
// older than entry i.
// Optional feature: define AGE_ISQ_ENQ_WAKEUP_EN so that the condition-update
// broadcasts also apply to the entry being enqueued in the same cycle.
`ifndef ROB_STATE_ROLLIBACK
`define ROB_STATE_ROLLIBACK 2'd2
`endif

module age_issue_queue #(
    parameter int DEPTH       = 8,
    parameter int DATA_WIDTH  = 248,
    parameter int COND_WIDTH  = 2,
    parameter int ROBID_WIDTH = 6,
    parameter int ROBID_LSB   = 241,
    parameter int WB_PORTS    = 2
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  enq_valid,
    output logic                                  enq_ready,
    input  logic [DATA_WIDTH-1:0]                 enq_data,
    input  logic [COND_WIDTH-1:0]                 enq_condition,
    output logic                                  deq_valid,
    input  logic                                  deq_ready,
    output logic [DATA_WIDTH-1:0]                 deq_data,
    output logic [COND_WIDTH-1:0]                 deq_condition,
    input  logic [WB_PORTS-1:0]                   upd_valid,
    input  logic [WB_PORTS*(ROBID_WIDTH+1)-1:0]   upd_robid,
    input  logic [WB_PORTS*COND_WIDTH-1:0]        upd_mask,
    input  logic [WB_PORTS*COND_WIDTH-1:0]        upd_cond,
    input  logic                                  flush_valid,
    input  logic [ROBID_WIDTH:0]                  flush_robid,
    input  logic [1:0]                            rob_state,
    output logic [$clog2(DEPTH+1)-1:0]            occupancy,
    output logic [DEPTH-1:0]                      valid_vec
);

    localparam int RBW   = ROBID_WIDTH + 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [COND_WIDTH-1:0] cond_q  [DEPTH];
    logic [COND_WIDTH-1:0] cond_d  [DEPTH];
    logic [DATA_WIDTH-1:0] data_q  [DEPTH];
    logic [DATA_WIDTH-1:0] data_d  [DEPTH];
    logic [DEPTH-1:0]      older_q [DEPTH];
    logic [DEPTH-1:0]      older_d [DEPTH];
    logic [OCC_W-1:0]      occ_q, occ_d;

    logic                  flush_act;
    logic                  deq_fire;
    logic                  enq_fire;
    logic [DEPTH-1:0]      ready;
    logic [DEPTH-1:0]      sel;
    logic [DEPTH-1:0]      kill;
    logic [DEPTH-1:0]      free_vec;
    logic [DEPTH-1:0]      enq_oh;
    logic [COND_WIDTH-1:0] enq_cond_w;

    assign flush_act = flush_valid && (rob_state == `ROB_STATE_ROLLIBACK);
    assign occupancy = occ_q;
    assign valid_vec = valid_q;

    // Readiness, oldest-ready selection and rollback kill set per entry
    always_comb begin
        ready = '0;
        sel   = '0;
        kill  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = valid_q[i] & (&cond_q[i]);
        end
        for (int i = 0; i < DEPTH; i++) begin
            sel[i]  = ready[i] & ~flush_act & ~(|(ready & older_q[i]));
            kill[i] = valid_q[i] &
                      (data_q[i][ROBID_LSB+ROBID_WIDTH] ^ flush_robid[ROBID_WIDTH] ^
                       (data_q[i][ROBID_LSB +: ROBID_WIDTH] > flush_robid[ROBID_WIDTH-1:0]));
        end
    end

    // Dequeue port: one-hot selection muxed onto the outputs, zero when idle
    always_comb begin
        deq_data      = '0;
        deq_condition = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
                deq_data      = deq_data | data_q[i];
                deq_condition = deq_condition | cond_q[i];
            end
        end
    end

    assign deq_valid = |sel;
    assign deq_fire  = deq_valid & deq_ready;
    // Occupancy is registered, so a slot freed this cycle is only offered
    // once the count has dropped on the following cycle.
    assign enq_ready = (occ_q < DEPTH_C) & ~flush_act;
    assign enq_fire  = enq_valid & enq_ready;
    assign free_vec  = ~valid_q;
    assign enq_oh    = free_vec & (~free_vec + DEPTH'(1));

    // Condition written with a new entry, optionally merged with same-cycle updates
    always_comb begin
        enq_cond_w = enq_condition;
`ifdef AGE_ISQ_ENQ_WAKEUP_EN
        for (int p = 0; p < WB_PORTS; p++) begin
            if (upd_valid[p] && (enq_data[ROBID_LSB +: RBW] == upd_robid[p*RBW +: RBW])) begin
                enq_cond_w = (enq_cond_w & ~upd_mask[p*COND_WIDTH +: COND_WIDTH]) |
                             (upd_cond[p*COND_WIDTH +: COND_WIDTH] &
                              upd_mask[p*COND_WIDTH +: COND_WIDTH]);
            end
        end
`endif
    end

    // Next state: updates, flush/dequeue invalidation, enqueue, age bookkeeping
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            cond_d[i]  = cond_q[i];
            data_d[i]  = data_q[i];
            older_d[i] = older_q[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                // Ascending port order so the highest-numbered port wins overlaps
                for (int p = 0; p < WB_PORTS; p++) begin
                    if (upd_valid[p] && (data_q[i][ROBID_LSB +: RBW] == upd_robid[p*RBW +: RBW])) begin
                        cond_d[i] = (cond_d[i] & ~upd_mask[p*COND_WIDTH +: COND_WIDTH]) |
                                    (upd_cond[p*COND_WIDTH +: COND_WIDTH] &
                                     upd_mask[p*COND_WIDTH +: COND_WIDTH]);
                    end
                end
            end
            if (flush_act && kill[i]) begin
                valid_d[i] = 1'b0;
            end
            if (deq_fire && sel[i]) begin
                valid_d[i] = 1'b0;
            end
            if (enq_fire && enq_oh[i]) begin
                valid_d[i] = 1'b1;
                data_d[i]  = enq_data;
                cond_d[i]  = enq_cond_w;
                // Every entry still resident is older than the newcomer
                older_d[i] = valid_q;
            end
        end
        // Rows and columns of entries that are not valid next cycle are cleared
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                older_d[i][j] = older_d[i][j] & valid_d[i] & valid_d[j];
            end
        end
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cond_q[i]  <= '0;
                data_q[i]  <= '0;
                older_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int i = 0; i < DEPTH; i++) begin
                cond_q[i]  <= cond_d[i];
                data_q[i]  <= data_d[i];
                older_q[i] <= older_d[i];
            end
        end
    end

endmodule

// File: tb/tb_age_issue_queue.sv
// tb_age_issue_queue: directed stimulus with a dequeue scoreboard.
// Stimulus pushes the payload expected on each dequeue; a monitor pops and
// compares on every accepted dequeue.
`ifndef ROB_STATE_ROLLIBACK
`define ROB_STATE_ROLLIBACK 2'd2
`endif

module tb_age_issue_queue;

    localparam int DW  = 248;
    localparam int CW  = 2;
    localparam int RW  = 6;
    localparam int RBW = RW + 1;
    localparam int LSB = 241;
    localparam int WBP = 2;
    localparam int DEP = 8;
    localparam int OW  = $clog2(DEP + 1);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] cond;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              enq_valid;
    logic              enq_ready;
    logic [DW-1:0]     enq_data;
    logic [CW-1:0]     enq_condition;
    logic              deq_valid;
    logic              deq_ready;
    logic [DW-1:0]     deq_data;
    logic [CW-1:0]     deq_condition;
    logic [WBP-1:0]    upd_valid;
    logic [WBP*RBW-1:0] upd_robid;
    logic [WBP*CW-1:0] upd_mask;
    logic [WBP*CW-1:0] upd_cond;
    logic              flush_valid;
    logic [RW:0]       flush_robid;
    logic [1:0]        rob_state;
    logic [OW-1:0]     occupancy;
    logic [DEP-1:0]    valid_vec;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];

    age_issue_queue dut (
        .clock(clock), .reset_n(reset_n),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_data(enq_data), .enq_condition(enq_condition),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_data(deq_data), .deq_condition(deq_condition),
        .upd_valid(upd_valid), .upd_robid(upd_robid),
        .upd_mask(upd_mask), .upd_cond(upd_cond),
        .flush_valid(flush_valid), .flush_robid(flush_robid), .rob_state(rob_state),
        .occupancy(occupancy), .valid_vec(valid_vec)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] mk(input logic [RBW-1:0] r, input logic [31:0] tag);
        logic [DW-1:0] d;
        d = '0;
        d[LSB +: RBW] = r;
        d[31:0] = tag;
        return d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_deq(input logic [RBW-1:0] r, input logic [31:0] tag);
        exp_t e;
        e.data = mk(r, tag);
        e.cond = 2'b11;
        exp_q.push_back(e);
    endtask

    task automatic enq1(input logic [RBW-1:0] r, input logic [CW-1:0] c, input logic [31:0] tag);
        enq_valid     = 1'b1;
        enq_data      = mk(r, tag);
        enq_condition = c;
        tick();
        enq_valid     = 1'b0;
    endtask

    task automatic set_upd(input int p, input logic [RBW-1:0] r,
                           input logic [CW-1:0] m, input logic [CW-1:0] c);
        upd_valid[p]          = 1'b1;
        upd_robid[p*RBW +: RBW] = r;
        upd_mask[p*CW +: CW]  = m;
        upd_cond[p*CW +: CW]  = c;
    endtask

    task automatic clr_upd();
        upd_valid = '0;
        upd_robid = '0;
        upd_mask  = '0;
        upd_cond  = '0;
    endtask

    // Scoreboard monitor: compare every accepted dequeue against the queue head
    always @(negedge clock) begin
        if (reset_n && deq_valid && deq_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL deq_unexpected actual_robid=%0h required=none", deq_data[LSB +: RBW]);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (deq_data !== e.data || deq_condition !== e.cond) begin
                    failures++;
                    $display("FAIL deq_payload actual_robid=%0h tag=%0h cond=%0b required_robid=%0h tag=%0h cond=%0b",
                             deq_data[LSB +: RBW], deq_data[31:0], deq_condition,
                             e.data[LSB +: RBW], e.data[31:0], e.cond);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n       = 1'b0;
        enq_valid     = 1'b0;
        enq_data      = '0;
        enq_condition = '0;
        deq_ready     = 1'b0;
        flush_valid   = 1'b0;
        flush_robid   = '0;
        rob_state     = 2'd0;
        clr_upd();
        #12;
        chk("reset_occupancy", 64'(occupancy), 64'd0);
        chk("reset_valid_vec", 64'(valid_vec), 64'd0);
        chk("reset_deq_valid", 64'(deq_valid), 64'd0);
        chk("reset_enq_ready", 64'(enq_ready), 64'd1);
        reset_n = 1'b1;
        tick();

        // In-order dequeue of two ready entries
        enq1(7'd3, 2'b11, 32'h101);
        enq1(7'd4, 2'b11, 32'h102);
        chk("t1_occ2", 64'(occupancy), 64'd2);
        expect_deq(7'd3, 32'h101);
        expect_deq(7'd4, 32'h102);
        deq_ready = 1'b1;
        tick();
        chk("t1_occ1", 64'(occupancy), 64'd1);
        tick();
        chk("t1_occ0", 64'(occupancy), 64'd0);
        deq_ready = 1'b0;

        // Older non-ready entry does not block; update wakes it
        enq1(7'd6, 2'b01, 32'h201);
        enq1(7'd7, 2'b11, 32'h202);
        expect_deq(7'd7, 32'h202);
        deq_ready = 1'b1;
        tick();
        chk("t2_a_not_ready", 64'(deq_valid), 64'd0);
        set_upd(0, 7'd6, 2'b10, 2'b10);
        tick();
        clr_upd();
        expect_deq(7'd6, 32'h201);
        tick();
        chk("t2_occ0", 64'(occupancy), 64'd0);
        deq_ready = 1'b0;

        // Full queue, freed slot only reusable on the following cycle
        for (int k = 0; k < DEP; k++) enq1(7'(16 + k), 2'b11, 32'(k));
        chk("t3_full_occ", 64'(occupancy), 64'd8);
        chk("t3_full_enq_ready", 64'(enq_ready), 64'd0);
        expect_deq(7'd16, 32'd0);
        deq_ready     = 1'b1;
        enq_valid     = 1'b1;
        enq_data      = mk(7'd30, 32'h55);
        enq_condition = 2'b00;
        chk("t3_enq_ready_same_cycle", 64'(enq_ready), 64'd0);
        tick();
        deq_ready = 1'b0;
        chk("t3_enq_ready_next", 64'(enq_ready), 64'd1);
        chk("t3_freed_slot", 64'(valid_vec), 64'hFE);
        tick();
        enq_valid = 1'b0;
        chk("t3_refill_vec", 64'(valid_vec), 64'hFF);
        for (int k = 1; k < DEP; k++) expect_deq(7'(16 + k), 32'(k));
        deq_ready = 1'b1;
        repeat (DEP - 1) tick();
        deq_ready = 1'b0;
        chk("t3_refill_index0", 64'(valid_vec), 64'h01);
        set_upd(0, 7'd30, 2'b11, 2'b11);
        tick();
        clr_upd();
        expect_deq(7'd30, 32'h55);
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        chk("t3_occ0", 64'(occupancy), 64'd0);

        // Rollback flush across the robid wrap
        enq1(7'h3E, 2'b11, 32'h401);
        enq1(7'h3F, 2'b00, 32'h402);
        enq1(7'h40, 2'b00, 32'h403);
        enq1(7'h41, 2'b00, 32'h404);
        chk("t4_pre_flush_deq_valid", 64'(deq_valid), 64'd1);
        flush_valid   = 1'b1;
        rob_state     = `ROB_STATE_ROLLIBACK;
        flush_robid   = 7'h3F;
        deq_ready     = 1'b1;
        enq_valid     = 1'b1;
        enq_data      = mk(7'h50, 32'h405);
        enq_condition = 2'b11;
        set_upd(0, 7'h3F, 2'b11, 2'b11);
        #1;
        chk("t4_flush_deq_valid", 64'(deq_valid), 64'd0);
        chk("t4_flush_enq_ready", 64'(enq_ready), 64'd0);
        chk("t4_flush_deq_data_zero", 64'(|deq_data), 64'd0);
        tick();
        flush_valid = 1'b0;
        rob_state   = 2'd0;
        enq_valid   = 1'b0;
        clr_upd();
        chk("t4_occ2", 64'(occupancy), 64'd2);
        chk("t4_survivors", 64'(valid_vec), 64'h03);
        expect_deq(7'h3E, 32'h401);
        expect_deq(7'h3F, 32'h402);
        tick();
        tick();
        deq_ready = 1'b0;
        chk("t4_occ0", 64'(occupancy), 64'd0);

        // Same-cycle update of an entry being enqueued
        enq_valid     = 1'b1;
        enq_data      = mk(7'd5, 32'h501);
        enq_condition = 2'b00;
        set_upd(1, 7'd5, 2'b11, 2'b11);
        tick();
        enq_valid = 1'b0;
        clr_upd();
`ifdef AGE_ISQ_ENQ_WAKEUP_EN
        chk("t5_enq_wakeup", 64'(deq_valid), 64'd1);
`else
        chk("t5_enq_no_wakeup", 64'(deq_valid), 64'd0);
`endif
        set_upd(0, 7'd5, 2'b11, 2'b11);
        tick();
        clr_upd();
        expect_deq(7'd5, 32'h501);
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        chk("t5_occ0", 64'(occupancy), 64'd0);

        // Overlapping ports: the higher port is applied last
        enq1(7'd9, 2'b00, 32'h601);
        set_upd(0, 7'd9, 2'b01, 2'b01);
        set_upd(1, 7'd9, 2'b11, 2'b10);
        tick();
        clr_upd();
        chk("t6_cond10_not_ready", 64'(deq_valid), 64'd0);
        set_upd(0, 7'd9, 2'b01, 2'b01);
        tick();
        clr_upd();
        chk("t6_now_ready", 64'(deq_valid), 64'd1);
        chk("t6_cond11", 64'(deq_condition), 64'h3);
        expect_deq(7'd9, 32'h601);
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;

        // Asynchronous reset in the middle of operation
        for (int k = 0; k < 4; k++) enq1(7'(40 + k), 2'b11, 32'(k));
        chk("t7_occ4", 64'(occupancy), 64'd4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t7_reset_occ", 64'(occupancy), 64'd0);
        chk("t7_reset_deq_valid", 64'(deq_valid), 64'd0);
        chk("t7_reset_valid_vec", 64'(valid_vec), 64'd0);
        #5;
        reset_n = 1'b1;
        tick();
        chk("t7_post_enq_ready", 64'(enq_ready), 64'd1);
        chk("t7_post_occ", 64'(occupancy), 64'd0);

        tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/age_issue_queue.md
AGE_ISSUE_QUEUE -- requirements
Module: age_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of entries, 2..32.
REQ-002 SHALL have parameter DATA_WIDTH, default 248: payload width.
REQ-003 SHALL have parameter COND_WIDTH, default 2: readiness condition bits per entry.
REQ-004 SHALL have parameter ROBID_WIDTH, default 6: rob index width; robids carry one extra wrap bit (ROBID_WIDTH+1 total).
REQ-005 SHALL have parameter ROBID_LSB, default 241: robid position in payload, data[ROBID_LSB +: ROBID_WIDTH+1].
REQ-006 SHALL have parameter WB_PORTS, default 2: number of condition-update broadcast ports.
REQ-007 SHALL have port clock, input, 1: sole clock, rising edge.
REQ-008 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-009 SHALL have ports enq_valid in 1, enq_ready out 1, enq_data in DATA_WIDTH, enq_condition in COND_WIDTH: enqueue.
REQ-010 SHALL have ports deq_valid out 1, deq_ready in 1, deq_data out DATA_WIDTH, deq_condition out COND_WIDTH: dequeue.
REQ-011 SHALL have ports upd_valid in WB_PORTS, upd_robid in WB_PORTS x (ROBID_WIDTH+1), upd_mask in WB_PORTS x COND_WIDTH, upd_cond in WB_PORTS x COND_WIDTH: condition updates.
REQ-012 SHALL have ports flush_valid in 1, flush_robid in ROBID_WIDTH+1, rob_state in 2: rollback flush.
REQ-013 SHALL have ports occupancy out $clog2(DEPTH+1) and valid_vec out DEPTH: status.

Function
REQ-014 Entry ready SHALL mean valid and all condition bits 1.
REQ-015 Age matrix SHALL record relative order of valid entries; new entry is younger than every valid entry.
REQ-016 deq_valid SHALL be asserted combinationally when any entry is ready and no flush is active; the selected entry is the oldest ready entry (older non-ready entries do not block).
REQ-017 deq_data/deq_condition SHALL show the selected entry, zero when deq_valid=0.
REQ-018 deq_valid&deq_ready SHALL invalidate the selected entry and clear its age row/column at the next edge.
REQ-019 enq_ready SHALL be 1 iff occupancy<DEPTH and no flush is active; an entry freed in the same cycle is not reusable until the following cycle.
REQ-020 enq_valid&enq_ready SHALL write the lowest-index free entry at the next edge; visible to selection from the following cycle.
REQ-021 Update port p SHALL, for each valid entry whose robid equals upd_robid[p], set condition = (condition & ~upd_mask[p]) | (upd_cond[p] & upd_mask[p]) at the next edge; overlapping ports SHALL be applied in ascending port order (highest port wins).
REQ-022 Flush is active when flush_valid=1 and rob_state equals `ROB_STATE_ROLLIBACK; each valid entry with entry_wrap ^ flush_wrap ^ (entry_idx > flush_idx) = 1 SHALL be invalidated at the next edge; entry equal to flush_robid SHALL be kept.
REQ-023 During active flush, enqueue and dequeue SHALL be suppressed; updates SHALL still apply to surviving entries.
REQ-024 occupancy SHALL equal popcount(valid_vec), registered, updated every edge.

Reset
REQ-025 On reset_n low, asynchronously: all entries invalid, age matrix zero, conditions zero, occupancy 0, valid_vec 0, deq_valid 0, enq_ready 1 after reset.
REQ-026 Reset mid-operation SHALL discard all entries; no partial enqueue/dequeue survives.

Configuration
REQ-027 Macro AGE_ISQ_ENQ_WAKEUP_EN defined: update ports SHALL also compare against enq_data robid and merge into the condition written on enqueue (same REQ-021 rules).
REQ-028 Macro undefined: an enqueued entry SHALL receive enq_condition unmodified; same-cycle updates for it are lost.

Verification
REQ-029 Enqueue A(robid 3,cond 11), B(robid 4,cond 11) -> deq A then B, one per cycle with deq_ready=1; occupancy 2,1,0.
REQ-030 Enqueue A(cond 01), B(cond 11) -> B dequeued first; then upd robid=A,mask 10,cond 10 -> A dequeued next cycle.
REQ-031 Fill 8 entries -> enq_ready=0; dequeue one -> enq_ready=0 that cycle, 1 next cycle, refill uses freed index.
REQ-032 Entries robid 0x3E,0x3F,0x40,0x41 (wrap), flush_robid=0x3F in rollback -> 0x40,0x41 invalidated, 0x3E,0x3F kept, occupancy 2.
REQ-033 Enqueue robid 5 cond 00 with simultaneous upd robid 5 mask 11 cond 11 -> with AGE_ISQ_ENQ_WAKEUP_EN deq_valid next cycle; without, deq_valid stays 0.
REQ-034 Two ports same robid, masks 01 and 11, conds 01 and 10 -> final condition 10; reset_n pulsed with 4 entries -> occupancy 0, deq_valid 0.
